// File: rtl/pe_ni.sv
// Processing-element network interface: injection FIFO, registered
// ejection and traffic counters. Option macro: PE_NI_STALL_CNT_EN.
module pe_ni #(
  parameter int X_W   = 2,
  parameter int Y_W   = 2,
  parameter int D_W   = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [X_W-1:0]   tx_x,
  input  logic [Y_W-1:0]   tx_y,
  input  logic [D_W-1:0]   tx_d,
  input  logic             tx_v,
  output logic             tx_rdy,
  output logic [X_W-1:0]   i_x,
  output logic [Y_W-1:0]   i_y,
  output logic [D_W-1:0]   i_d,
  output logic             i_v,
  input  logic             i_ack,
  input  logic             o_v,
  input  logic [D_W-1:0]   o_d,
  output logic             rx_v,
  output logic [D_W-1:0]   rx_d,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] rx_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = X_W + Y_W + D_W;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  // Extra pointer MSB tells a full ring from an empty one.
  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
  assign tx_rdy = !full;
  assign i_v    = !empty;
  assign push   = tx_v && !full;
  assign pop    = i_v && i_ack;

  assign head = mem[rptr[AW-1:0]];
  assign {i_x, i_y, i_d} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr[AW-1:0]] <= {tx_x, tx_y, tx_d};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_v <= 1'b0;
      rx_d <= '0;
    end else begin
      rx_v <= o_v;
      if (o_v) rx_d <= o_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= '0;
      rx_cnt <= '0;
    end else begin
      if (pop) tx_cnt <= tx_cnt + CNT_W'(1);
      if (o_v) rx_cnt <= rx_cnt + CNT_W'(1);
    end
  end

`ifdef PE_NI_STALL_CNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (i_v && !i_ack) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pe_ni.sv
// Self-checking bench for pe_ni: directed scenarios plus a
// negedge scoreboard on the injection and ejection paths.
module tb_pe_ni;

  localparam int X_W   = 2;
  localparam int Y_W   = 2;
  localparam int D_W   = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

`ifdef PE_NI_STALL_CNT_EN
  localparam logic [CNT_W-1:0] HOLD_STALL = 4'd7;
`else
  localparam logic [CNT_W-1:0] HOLD_STALL = 4'd0;
`endif

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [D_W-1:0] d;
  } pkt_t;

  logic             clk;
  logic             rst;
  logic [X_W-1:0]   tx_x;
  logic [Y_W-1:0]   tx_y;
  logic [D_W-1:0]   tx_d;
  logic             tx_v;
  logic             tx_rdy;
  logic [X_W-1:0]   i_x;
  logic [Y_W-1:0]   i_y;
  logic [D_W-1:0]   i_d;
  logic             i_v;
  logic             i_ack;
  logic             o_v;
  logic [D_W-1:0]   o_d;
  logic             rx_v;
  logic [D_W-1:0]   rx_d;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;
  logic [CNT_W-1:0] stall_cnt;

  int errs;
  int checks;
  int n_push;
  int n_ov;
  logic prev_ov;
  pkt_t txq[$];
  logic [D_W-1:0] rxq[$];

  pe_ni #(
    .X_W(X_W), .Y_W(Y_W), .D_W(D_W),
    .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_x(tx_x), .tx_y(tx_y), .tx_d(tx_d),
    .tx_v(tx_v), .tx_rdy(tx_rdy),
    .i_x(i_x), .i_y(i_y), .i_d(i_d),
    .i_v(i_v), .i_ack(i_ack),
    .o_v(o_v), .o_d(o_d),
    .rx_v(rx_v), .rx_d(rx_d),
    .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: inputs are stable at negedge, transfer at next posedge.
  always @(negedge clk) begin
    pkt_t got;
    pkt_t exp;
    logic [D_W-1:0] ed;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      checks++;
      if (rx_v !== prev_ov) begin
        errs++;
        $display("FAIL sb_rx_v got %b want %b", rx_v, prev_ov);
      end
      if (rx_v === 1'b1) begin
        checks++;
        if (rxq.size() == 0) begin
          errs++;
          $display("FAIL sb_rx_extra got %h want none", rx_d);
        end else begin
          ed = rxq.pop_front();
          if (rx_d !== ed) begin
            errs++;
            $display("FAIL sb_rx_d got %h want %h", rx_d, ed);
          end
        end
      end
      if (o_v) begin
        rxq.push_back(o_d);
        n_ov++;
      end
      prev_ov = o_v;
      if (i_v && i_ack) begin
        got = {i_x, i_y, i_d};
        checks++;
        if (txq.size() == 0) begin
          errs++;
          $display("FAIL sb_pop_empty got %h want none", got);
        end else begin
          exp = txq.pop_front();
          if (got !== exp) begin
            errs++;
            $display("FAIL sb_inj got %h want %h", got, exp);
          end
        end
      end
      if (tx_v && tx_rdy) begin
        txq.push_back({tx_x, tx_y, tx_d});
        n_push++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tx_v  = 1'b0;
    tx_x  = '0;
    tx_y  = '0;
    tx_d  = '0;
    i_ack = 1'b0;
    o_v   = 1'b0;
    o_d   = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    #1;
    txq.delete();
    rxq.delete();
    n_push = 0;
    n_ov = 0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    #1;
    checks += 7;
    if (i_v !== 1'b0) begin
      errs++; $display("FAIL rst_i_v got %b want 0", i_v);
    end
    if (tx_rdy !== 1'b1) begin
      errs++; $display("FAIL rst_tx_rdy got %b want 1", tx_rdy);
    end
    if (rx_v !== 1'b0) begin
      errs++; $display("FAIL rst_rx_v got %b want 0", rx_v);
    end
    if (rx_d !== '0) begin
      errs++; $display("FAIL rst_rx_d got %h want 0", rx_d);
    end
    if (tx_cnt !== '0) begin
      errs++; $display("FAIL rst_tx_cnt got %0d want 0", tx_cnt);
    end
    if (rx_cnt !== '0) begin
      errs++; $display("FAIL rst_rx_cnt got %0d want 0", rx_cnt);
    end
    if (stall_cnt !== '0) begin
      errs++;
      $display("FAIL rst_stall got %0d want 0", stall_cnt);
    end
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    tx_v = 1'b1; tx_x = 2'd1; tx_y = 2'd2;
    tx_d = 32'hA5; i_ack = 1'b1;
    cyc();
    tx_v = 1'b0;
    checks += 3;
    if (i_v !== 1'b1) begin
      errs++; $display("FAIL single_i_v got %b want 1", i_v);
    end
    if ({i_x, i_y} !== 4'b0110) begin
      errs++;
      $display("FAIL single_xy got %b want 0110", {i_x, i_y});
    end
    if (i_d !== 32'hA5) begin
      errs++; $display("FAIL single_i_d got %h want a5", i_d);
    end
    cyc();
    checks += 2;
    if (i_v !== 1'b0) begin
      errs++; $display("FAIL single_done got %b want 0", i_v);
    end
    if (tx_cnt !== 4'd1) begin
      errs++;
      $display("FAIL single_tx_cnt got %0d want 1", tx_cnt);
    end
    i_ack = 1'b0;
  endtask

  task automatic test_fill();
    do_reset();
    i_ack = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tx_v = 1'b1;
      tx_d = 32'(k);
      checks++;
      if (tx_rdy !== (k < 5)) begin
        errs++;
        $display("FAIL fill_rdy%0d got %b want %b",
                 k, tx_rdy, (k < 5));
      end
      cyc();
    end
    tx_v = 1'b0;
    i_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (i_v !== 1'b1 || i_d !== 32'(k)) begin
        errs++;
        $display("FAIL fill_drain%0d got %b/%h want 1/%h",
                 k, i_v, i_d, 32'(k));
      end
      cyc();
    end
    checks += 2;
    if (i_v !== 1'b0) begin
      errs++; $display("FAIL fill_empty got %b want 0", i_v);
    end
    if (tx_cnt !== 4'd4) begin
      errs++; $display("FAIL fill_tx_cnt got %0d want 4", tx_cnt);
    end
    i_ack = 1'b0;
  endtask

  task automatic test_head_hold();
    do_reset();
    tx_v = 1'b1; tx_x = 2'd3; tx_y = 2'd1;
    tx_d = 32'h3C; i_ack = 1'b0;
    cyc();
    tx_v = 1'b0;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (i_v !== 1'b1 || i_d !== 32'h3C ||
          i_x !== 2'd3 || i_y !== 2'd1) begin
        errs++;
        $display("FAIL hold%0d got %b/%h want 1/3c", k, i_v, i_d);
      end
      cyc();
    end
    checks++;
    if (stall_cnt !== HOLD_STALL) begin
      errs++;
      $display("FAIL hold_stall got %0d want %0d",
               stall_cnt, HOLD_STALL);
    end
    i_ack = 1'b1;
    cyc();
    i_ack = 1'b0;
    checks++;
    if (i_v !== 1'b0) begin
      errs++; $display("FAIL hold_pop got %b want 0", i_v);
    end
  endtask

  task automatic test_eject();
    do_reset();
    tx_v = 1'b1; tx_d = 32'h55; i_ack = 1'b1;
    o_v = 1'b1; o_d = 32'h11;
    cyc();
    tx_v = 1'b0;
    o_d = 32'h22;
    checks++;
    if (rx_v !== 1'b1 || rx_d !== 32'h11) begin
      errs++;
      $display("FAIL ej_first got %b/%h want 1/11", rx_v, rx_d);
    end
    cyc();
    o_v = 1'b0;
    o_d = 32'h99;
    checks++;
    if (rx_v !== 1'b1 || rx_d !== 32'h22) begin
      errs++;
      $display("FAIL ej_second got %b/%h want 1/22", rx_v, rx_d);
    end
    cyc();
    checks += 3;
    if (rx_v !== 1'b0 || rx_d !== 32'h22) begin
      errs++;
      $display("FAIL ej_hold got %b/%h want 0/22", rx_v, rx_d);
    end
    if (rx_cnt !== 4'd2) begin
      errs++; $display("FAIL ej_rx_cnt got %0d want 2", rx_cnt);
    end
    if (tx_cnt !== 4'd1) begin
      errs++; $display("FAIL ej_tx_cnt got %0d want 1", tx_cnt);
    end
    i_ack = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    i_ack = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tx_v = 1'b1;
      tx_d = 32'(256 + k);
      tx_x = 2'(k);
      tx_y = 2'(k >> 2);
      cyc();
    end
    tx_v = 1'b0;
    checks++;
    if (tx_cnt !== 4'd15) begin
      errs++; $display("FAIL wrap_15 got %0d want 15", tx_cnt);
    end
    cyc();
    checks += 2;
    if (tx_cnt !== 4'd0) begin
      errs++; $display("FAIL wrap_0 got %0d want 0", tx_cnt);
    end
    if (i_v !== 1'b0) begin
      errs++; $display("FAIL wrap_empty got %b want 0", i_v);
    end
    i_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tx_v = 1'b1;
      tx_d = 32'hC0 + 32'(k);
      cyc();
    end
    tx_v = 1'b0;
    checks++;
    if (i_v !== 1'b1) begin
      errs++; $display("FAIL mid_queued got %b want 1", i_v);
    end
    #2;
    rst = 1'b1;
    #1;
    txq.delete();
    checks += 2;
    if (i_v !== 1'b0) begin
      errs++; $display("FAIL mid_i_v got %b want 0", i_v);
    end
    if (tx_rdy !== 1'b1) begin
      errs++; $display("FAIL mid_rdy got %b want 1", tx_rdy);
    end
    cyc();
    rst = 1'b0;
    n_push = 0;
    n_ov = 0;
    cyc();
    checks++;
    if (i_v !== 1'b0 || tx_rdy !== 1'b1) begin
      errs++;
      $display("FAIL mid_stale got %b/%b want 0/1", i_v, tx_rdy);
    end
    tx_v = 1'b1; tx_d = 32'h77; i_ack = 1'b1;
    cyc();
    tx_v = 1'b0;
    checks++;
    if (i_v !== 1'b1 || i_d !== 32'h77) begin
      errs++;
      $display("FAIL mid_new got %b/%h want 1/77", i_v, i_d);
    end
    cyc();
    checks++;
    if (i_v !== 1'b0) begin
      errs++; $display("FAIL mid_after got %b want 0", i_v);
    end
    i_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    for (int k = 0; k < 300; k++) begin
      tx_v  = 1'($urandom_range(0, 1));
      tx_x  = 2'($urandom);
      tx_y  = 2'($urandom);
      tx_d  = $urandom;
      i_ack = ($urandom_range(0, 3) != 0);
      o_v   = 1'($urandom_range(0, 1));
      o_d   = $urandom;
      cyc();
    end
    tx_v = 1'b0;
    o_v = 1'b0;
    i_ack = 1'b1;
    n = 0;
    while (i_v === 1'b1 && n < 2 * DEPTH) begin
      cyc();
      n++;
    end
    cyc();
    checks += 4;
    if (i_v !== 1'b0) begin
      errs++; $display("FAIL b2b_drain got %b want 0", i_v);
    end
    if (txq.size() != 0 || rxq.size() != 0) begin
      errs++;
      $display("FAIL b2b_left got %0d/%0d want 0/0",
               txq.size(), rxq.size());
    end
    if (tx_cnt !== CNT_W'(n_push)) begin
      errs++;
      $display("FAIL b2b_tx_cnt got %0d want %0d",
               tx_cnt, CNT_W'(n_push));
    end
    if (rx_cnt !== CNT_W'(n_ov)) begin
      errs++;
      $display("FAIL b2b_rx_cnt got %0d want %0d",
               rx_cnt, CNT_W'(n_ov));
    end
    i_ack = 1'b0;
  endtask

  initial begin
    errs = 0;
    checks = 0;
    n_push = 0;
    n_ov = 0;
    prev_ov = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_head_hold();
    test_eject();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pe_ni.md
PE_NI -- requirements
Module: pe_ni

Interface
REQ-001 SHALL have parameter X_W, default 2: X address width.
REQ-002 SHALL have parameter Y_W, default 2: Y address width.
REQ-003 SHALL have parameter D_W, default 32: payload width.
REQ-004 SHALL have parameter DEPTH, default 4: injection FIFO depth; power of two, at least 2.
REQ-005 SHALL have parameter CNT_W, default 16: statistics counter width.
REQ-006 SHALL have port clk  input  1: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-008 SHALL have ports tx_x/tx_y/tx_d  input  X_W/Y_W/D_W: client packet destination X, destination Y and payload.
REQ-009 SHALL have port tx_v  input  1: client packet valid.
REQ-010 SHALL have port tx_rdy  output  1: NI can accept a client packet.
REQ-011 SHALL have ports i_x/i_y/i_d  output  X_W/Y_W/D_W: injection packet to the router.
REQ-012 SHALL have port i_v  output  1: injection valid.
REQ-013 SHALL have port i_ack  input  1: router accepted the injection this cycle.
REQ-014 SHALL have ports o_v/o_d  input  1/D_W: ejection from the router. The router ejects with no backpressure.
REQ-015 SHALL have ports rx_v/rx_d  output  1/D_W: registered delivery to the client.
REQ-016 SHALL have ports tx_cnt/rx_cnt/stall_cnt  output  CNT_W each: packets injected, packets received, and injection stall cycles.

Function
REQ-017 The injection FIFO SHALL store {x,y,d} entries and accept a push when tx_v && tx_rdy.
REQ-018 tx_rdy SHALL equal !full, combinationally from FIFO occupancy only; it SHALL NOT depend on i_ack.
REQ-019 i_v SHALL equal !empty, and i_x/i_y/i_d SHALL present the head entry.
REQ-020 The head entry and i_v SHALL stay stable until i_v && i_ack.
REQ-021 The FIFO SHALL pop exactly when i_v && i_ack; i_ack while i_v is low SHALL be ignored.
REQ-022 Latency: a packet pushed in cycle t SHALL make i_v high at cycle t+1 if the FIFO was empty.
REQ-023 Simultaneous push and pop SHALL keep occupancy unchanged and preserve FIFO order.
REQ-024 At full, tx_rdy is low, so a push is impossible even with a same-cycle pop.
REQ-025 Read/write pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH.
REQ-026 Full SHALL be detected as MSBs differing with the low bits equal; empty as the pointers being equal.
REQ-027 Packets addressed to the NI's own node SHALL be injected unchanged; local delivery is the router's job.
REQ-028 Each cycle, rx_v SHALL be loaded with o_v; rx_d SHALL be loaded with o_d when o_v is high and hold otherwise.
REQ-029 Ejection latency SHALL be 1 cycle, and no ejected packet SHALL ever be dropped.
REQ-030 tx_cnt SHALL increment on each pop and wrap modulo 2^CNT_W.
REQ-031 rx_cnt SHALL increment on each cycle with o_v high and wrap modulo 2^CNT_W.
REQ-032 Injection and ejection in the same cycle SHALL update both counters independently.

Reset
REQ-033 Asserting rst SHALL immediately, without a clock edge, clear both FIFO pointers.
REQ-034 Asserting rst SHALL immediately force i_v=0, tx_rdy=1, rx_v=0, rx_d=0, tx_cnt=0, rx_cnt=0 and stall_cnt=0.
REQ-035 Reset mid-operation SHALL discard all queued packets, including an unacknowledged head.
REQ-036 Reset SHALL NOT require the FIFO storage array to be cleared.
REQ-037 On the first rising edge after rst deasserts, the NI SHALL accept a push.

Configuration
REQ-038 With macro PE_NI_STALL_CNT_EN defined, stall_cnt SHALL increment (wrapping) on each cycle with i_v && !i_ack.
REQ-039 Without PE_NI_STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter register SHALL be synthesised.
REQ-040 The port list SHALL be identical in both configurations.

Verification
REQ-041 Single injection: push {x=1,y=2,d=0xA5} at cycle 0 with i_ack held 1 -> i_v=1 with that packet at cycle 1, popped at cycle 1, i_v=0 at cycle 2, tx_cnt=1.
REQ-042 Fill: DEPTH=4, i_ack=0, push 5 packets d=1..5 -> tx_rdy low after the 4th push, 5th not accepted; then i_ack=1 -> i_d sequence 1,2,3,4, one per cycle.
REQ-043 Head hold: i_ack=0 for 7 cycles with packet d=0x3C queued -> i_v/i_d stable throughout, stall_cnt=7 when the macro is defined, 0 when not.
REQ-044 Ejection: o_v=1 with o_d=0x11 then 0x22 on consecutive cycles while injecting -> rx_v high with rx_d 0x11 then 0x22 one cycle later, rx_cnt=2, tx_cnt unaffected.
REQ-045 Wrap/reset: with CNT_W=4, 16 injections -> tx_cnt=0; with 3 packets queued, assert rst between clock edges -> i_v=0 and tx_rdy=1 before the next edge, and no stale packet after release.
